// File: rtl/delay_ctrl_pkg.sv
// Shared types, widths and the saturating step helper for the blink-delay
// control initiator.
package delay_ctrl_pkg;

  localparam int DELAY_W = 4;
  localparam int AVM_DW  = 32;
  localparam logic [DELAY_W-1:0] DELAY_MAX = 4'd15;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT_RD = 3'd0;
  localparam state_t ST_RD_WAIT = 3'd1;
  localparam state_t ST_IDLE    = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_WR_REQ  = 3'd4;

  // One step up (i_inc=1) or down, clamped to [0, DELAY_MAX].
  function automatic logic [DELAY_W-1:0] sat_step(input logic [DELAY_W-1:0] i_val,
                                                  input logic i_inc);
    logic [DELAY_W-1:0] w_res;
    if (i_inc) begin
      w_res = (i_val == DELAY_MAX) ? i_val : i_val + 4'd1;
    end else begin
      w_res = (i_val == 4'd0) ? i_val : i_val - 4'd1;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/delay_cmd_latch.sv
// Pending-command slots for slower/faster/restore. Pulses merge per kind;
// the decode sees live pulses too so an IDLE pulse is served without delay.
module delay_cmd_latch (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_slower,
  input  logic i_faster,
  input  logic i_restore,
  input  logic i_consume,
  output logic o_go_write,
  output logic o_go_read,
  output logic o_inc
);

  logic r_slower;
  logic r_faster;
  logic r_restore;
  logic w_slower;
  logic w_faster;
  logic w_restore;

  assign w_slower  = r_slower  | i_slower;
  assign w_faster  = r_faster  | i_faster;
  assign w_restore = r_restore | i_restore;

  // Set on pulse, cleared together when the FSM consumes them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slower  <= 1'b0;
      r_faster  <= 1'b0;
      r_restore <= 1'b0;
    end else if (i_consume) begin
      r_slower  <= 1'b0;
      r_faster  <= 1'b0;
      r_restore <= 1'b0;
    end else begin
      r_slower  <= w_slower;
      r_faster  <= w_faster;
      r_restore <= w_restore;
    end
  end

  // Restore wins; slower together with faster cancels out.
  assign o_go_write = w_restore;
  assign o_go_read  = ~w_restore & (w_slower ^ w_faster);
  assign o_inc      = w_slower;

endmodule

// File: rtl/delay_ctrl_master.sv
// Avalon-MM initiator turning key command pulses into read-modify-write
// transactions on the delay register, with a local mirror of the value.
module delay_ctrl_master
  import delay_ctrl_pkg::*;
#(
  parameter logic [3:0] DELAY_ADDR    = 4'd0,
  parameter logic [3:0] DEFAULT_DELAY = 4'd8,
  parameter logic [7:0] TIMEOUT       = 8'd255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_slower,
  input  logic               i_faster,
  input  logic               i_restore,
  output logic [DELAY_W-1:0] o_delay,
  output logic               o_busy,
  output logic               o_error,
  output logic [3:0]         o_avm_address,
  output logic               o_avm_read,
  output logic               o_avm_write,
  output logic [AVM_DW-1:0]  o_avm_writedata,
  output logic [3:0]         o_avm_byteenable,
  input  logic [AVM_DW-1:0]  i_avm_readdata,
  input  logic               i_avm_readdatavalid,
  input  logic               i_avm_waitrequest
);

  state_t               r_state;
  logic                 r_read;
  logic                 r_write;
  logic [3:0]           r_addr;
  logic [AVM_DW-1:0]    r_wdata;
  logic [3:0]           r_be;
  logic [DELAY_W-1:0]   r_delay;
  logic                 r_busy;
  logic                 r_error;
  logic [7:0]           r_tmo;
  logic                 r_inc;
  logic                 r_init;

  logic                 w_consume;
  logic                 w_go_write;
  logic                 w_go_read;
  logic                 w_inc;
  logic                 w_tmo_hit;
  logic [DELAY_W-1:0]   w_rd_val;
  logic                 w_unused_rd_hi;

  assign w_consume      = (r_state == ST_IDLE);
  assign w_tmo_hit      = (r_tmo == TIMEOUT);
  assign w_rd_val       = i_avm_readdata[DELAY_W-1:0];
  assign w_unused_rd_hi = ^i_avm_readdata[AVM_DW-1:DELAY_W];

  delay_cmd_latch u_cmd (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_slower   (i_slower),
    .i_faster   (i_faster),
    .i_restore  (i_restore),
    .i_consume  (w_consume),
    .o_go_write (w_go_write),
    .o_go_read  (w_go_read),
    .o_inc      (w_inc)
  );

  // Transaction FSM; all bus outputs are registered and only change on a state move.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT_RD;
      r_read  <= 1'b1;
      r_write <= 1'b0;
      r_addr  <= DELAY_ADDR;
      r_wdata <= {AVM_DW{1'b0}};
      r_be    <= 4'b0001;
      r_delay <= DEFAULT_DELAY;
      r_busy  <= 1'b1;
      r_error <= 1'b0;
      r_tmo   <= 8'd0;
      r_inc   <= 1'b0;
      r_init  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go_write) begin
            r_write <= 1'b1;
            r_wdata <= {{(AVM_DW-DELAY_W){1'b0}}, DEFAULT_DELAY};
            r_state <= ST_WR_REQ;
            r_busy  <= 1'b1;
            r_tmo   <= 8'd0;
          end else if (w_go_read) begin
            r_read  <= 1'b1;
            r_inc   <= w_inc;
            r_state <= ST_RD_REQ;
            r_busy  <= 1'b1;
            r_tmo   <= 8'd0;
          end else begin
            r_tmo   <= 8'd0;
          end
        end
        ST_INIT_RD, ST_RD_REQ: begin
          if (!i_avm_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_RD_WAIT;
            r_tmo   <= 8'd0;
          end else if (w_tmo_hit) begin
            r_read  <= 1'b0;
            r_error <= 1'b1;
            r_init  <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmo   <= r_tmo + 8'd1;
          end
        end
        ST_RD_WAIT: begin
          if (i_avm_readdatavalid) begin
            r_delay <= w_rd_val;
            r_tmo   <= 8'd0;
            if (r_init) begin
              r_init  <= 1'b0;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_write <= 1'b1;
              r_wdata <= {{(AVM_DW-DELAY_W){1'b0}}, sat_step(w_rd_val, r_inc)};
              r_state <= ST_WR_REQ;
            end
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_init  <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmo   <= r_tmo + 8'd1;
          end
        end
        ST_WR_REQ: begin
          if (!i_avm_waitrequest) begin
            r_write <= 1'b0;
            r_delay <= r_wdata[DELAY_W-1:0];
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tmo_hit) begin
            r_write <= 1'b0;
            r_error <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmo   <= r_tmo + 8'd1;
          end
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_init  <= 1'b0;
        end
      endcase
    end
  end

  assign o_delay          = r_delay;
  assign o_busy           = r_busy;
  assign o_error          = r_error;
  assign o_avm_address    = r_addr;
  assign o_avm_read       = r_read;
  assign o_avm_write      = r_write;
  assign o_avm_writedata  = r_wdata;
  assign o_avm_byteenable = r_be;

endmodule
